// File: rtl/normalizer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : normalizer_sequencer_if
//  Brief    : Operand/result handshake bundle for the normalizer sequencer.
//             slave  = normalizer side, master = producer/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface normalizer_sequencer_if #(
   parameter int EXP_WIDTH = 10
);
   logic                        in_valid;
   logic                        in_ready;
   logic [48:0]                 in_fraction;
   logic signed [EXP_WIDTH-1:0] in_exponent;

   logic                        out_valid;
   logic                        out_ready;
   logic [48:0]                 out_fraction;
   logic signed [EXP_WIDTH-1:0] out_exponent;
   logic                        out_zero;
   logic                        out_denormal;
   logic                        out_overflow;
   logic [5:0]                  out_cycles;

   modport master (
      output in_valid, in_fraction, in_exponent, out_ready,
      input  in_ready, out_valid, out_fraction, out_exponent,
             out_zero, out_denormal, out_overflow, out_cycles
   );

   modport slave (
      input  in_valid, in_fraction, in_exponent, out_ready,
      output in_ready, out_valid, out_fraction, out_exponent,
             out_zero, out_denormal, out_overflow, out_cycles
   );
endinterface
`default_nettype wire

// File: rtl/normalizer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : normalizer_sequencer
//  Brief    : Multi-cycle normalizer for a 49-bit [xx.xxxx...] fraction and
//             its signed biased exponent. Handles overflow (right shift by 1),
//             pass-through, and underflow (bounded left shifts of at most
//             SHIFT_STEP per cycle, stopping at the minimum normal exponent).
//  Options  : NORMALIZER_STICKY_EN - OR the bit dropped by the overflow right
//             shift into the new LSB so rounding keeps sticky information.
//  Revision : 1.0  initial release
// ============================================================================
module normalizer_sequencer #(
   parameter int SHIFT_STEP = 4,
   parameter int EXP_WIDTH  = 10,
   parameter int EXP_MAX    = 255
) (
   input  wire logic              clk,
   input  wire logic              reset,
   normalizer_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic signed [EXP_WIDTH-1:0] EXP_MAX_S = EXP_WIDTH'(EXP_MAX);
   localparam logic signed [EXP_WIDTH-1:0] EXP_ONE   = EXP_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [48:0]                 frac_q, frac_d;
   logic signed [EXP_WIDTH-1:0] exp_q, exp_d;
   logic                        zero_q, zero_d;
   logic                        den_q, den_d;
   logic                        ovf_q, ovf_d;
   logic [5:0]                  cyc_q, cyc_d;
   logic                        in_ready_q;
   logic                        out_valid_q;

   logic [5:0]                  lz;
   logic signed [EXP_WIDTH-1:0] exp_inc;
   logic signed [EXP_WIDTH-1:0] exp_room;
   int                          shift;
   logic [48:0]                 frac_rsh;

   assign exp_inc  = exp_q + EXP_ONE;
   assign exp_room = exp_q - EXP_ONE;

   // Leading zeros counted from bit 47 downward; highest set bit wins.
   always_comb begin
      lz = 6'd48;
      for (int i = 0; i <= 47; i++) begin
         if (frac_q[i]) lz = 6'(47 - i);
      end
   end

   // Shift distance: never past the leading one, the per-cycle cap, or E=1.
   always_comb begin
      shift = int'(lz);
      if (SHIFT_STEP < shift) shift = SHIFT_STEP;
      if (int'(exp_room) < shift) shift = int'(exp_room);
   end

   // Overflow right shift, optionally keeping the dropped bit as sticky.
   always_comb begin
`ifdef NORMALIZER_STICKY_EN
      frac_rsh = {1'b0, frac_q[48:2], frac_q[1] | frac_q[0]};
`else
      frac_rsh = {1'b0, frac_q[48:1]};
`endif
   end

   // Next-state and datapath update; holds everything by default.
   always_comb begin
      state_d = state_q;
      frac_d  = frac_q;
      exp_d   = exp_q;
      zero_d  = zero_q;
      den_d   = den_q;
      ovf_d   = ovf_q;
      cyc_d   = cyc_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               frac_d  = bus.in_fraction;
               exp_d   = bus.in_exponent;
               zero_d  = 1'b0;
               den_d   = 1'b0;
               ovf_d   = 1'b0;
               cyc_d   = 6'd0;
               state_d = NORM;
            end
         end
         NORM: begin
            cyc_d = cyc_q + 6'd1;
            if (frac_q[48]) begin
               frac_d  = frac_rsh;
               exp_d   = exp_inc;
               ovf_d   = (exp_inc >= EXP_MAX_S);
               state_d = DONE;
            end else if (frac_q[47]) begin
               ovf_d   = (exp_q >= EXP_MAX_S);
               state_d = DONE;
            end else if (frac_q == 49'd0) begin
               exp_d   = '0;
               zero_d  = 1'b1;
               ovf_d   = (EXP_WIDTH'(0) >= EXP_MAX_S);
               state_d = DONE;
            end else if (exp_q <= EXP_ONE) begin
               exp_d   = '0;
               den_d   = 1'b1;
               ovf_d   = (EXP_WIDTH'(0) >= EXP_MAX_S);
               state_d = DONE;
            end else begin
               frac_d  = frac_q << shift;
               exp_d   = exp_q - $signed(EXP_WIDTH'(shift));
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; handshake flags are registered decodes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         frac_q      <= '0;
         exp_q       <= '0;
         zero_q      <= 1'b0;
         den_q       <= 1'b0;
         ovf_q       <= 1'b0;
         cyc_q       <= 6'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frac_q      <= frac_d;
         exp_q       <= exp_d;
         zero_q      <= zero_d;
         den_q       <= den_d;
         ovf_q       <= ovf_d;
         cyc_q       <= cyc_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_fraction = frac_q;
   assign bus.out_exponent = exp_q;
   assign bus.out_zero     = zero_q;
   assign bus.out_denormal = den_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_cycles   = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_normalizer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_normalizer_sequencer
//  Brief    : Directed bench for normalizer_sequencer. Expected results are
//             queued when an operand is driven and compared when out_valid
//             rises (latency, fraction, exponent, flags, cycle count).
//  Revision : 1.0  initial release
// ============================================================================
module tb_normalizer_sequencer;

   localparam int EXP_WIDTH = 10;

   typedef struct {
      logic [48:0] frac;
      logic [9:0]  expo;
      logic        zero;
      logic        den;
      logic        ovf;
      logic [5:0]  cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   normalizer_sequencer_if #(.EXP_WIDTH(EXP_WIDTH)) bus ();

   normalizer_sequencer #(
      .SHIFT_STEP (4),
      .EXP_WIDTH  (EXP_WIDTH),
      .EXP_MAX    (255)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

`ifdef NORMALIZER_STICKY_EN
   localparam logic [48:0] OVF_FRAC = 49'h0_8000_0000_0001;
`else
   localparam logic [48:0] OVF_FRAC = 49'h0_8000_0000_0000;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic push_exp(input logic [48:0] f, input logic [9:0] e, input logic z,
                           input logic d, input logic o, input logic [5:0] c);
      exp_t x;
      x.frac = f; x.expo = e; x.zero = z; x.den = d; x.ovf = o; x.cyc = c;
      sb.push_back(x);
   endtask

   task automatic accept(input logic [48:0] f, input logic [9:0] e);
      check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
      bus.in_valid    = 1'b1;
      bus.in_fraction = f;
      bus.in_exponent = e;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic wait_and_compare();
      int         edges;
      exp_t       x;
      logic [9:0] e_obs;
      edges = 0;
      while (bus.out_valid !== 1'b1 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      if (bus.out_valid !== 1'b1) begin
         check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      end else if (sb.size() == 0) begin
         check("unexpected_result", 64'(sb.size()), 64'd1);
      end else begin
         x     = sb.pop_front();
         e_obs = bus.out_exponent;
         check("latency",      64'(edges),            64'(x.cyc));
         check("out_fraction", 64'(bus.out_fraction), 64'(x.frac));
         check("out_exponent", 64'(e_obs),            64'(x.expo));
         check("out_zero",     64'(bus.out_zero),     64'(x.zero));
         check("out_denormal", 64'(bus.out_denormal), 64'(x.den));
         check("out_overflow", 64'(bus.out_overflow), 64'(x.ovf));
         check("out_cycles",   64'(bus.out_cycles),   64'(x.cyc));
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("in_ready_after_release",  64'(bus.in_ready),  64'd1);
      check("out_valid_after_release", 64'(bus.out_valid), 64'd0);
   endtask

   task automatic run_op(input logic [48:0] f, input logic [9:0] e, input logic [48:0] ef,
                         input logic [9:0] ee, input logic z, input logic d, input logic o,
                         input logic [5:0] c);
      push_exp(ef, ee, z, d, o, c);
      accept(f, e);
      wait_and_compare();
      release_result();
   endtask

   initial begin
      logic [9:0] e_obs;
      logic       stale;
      bus.in_valid    = 1'b0;
      bus.in_fraction = '0;
      bus.in_exponent = '0;
      bus.out_ready   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      e_obs = bus.out_exponent;
      check("rst_in_ready",     64'(bus.in_ready),     64'd1);
      check("rst_out_valid",    64'(bus.out_valid),    64'd0);
      check("rst_out_fraction", 64'(bus.out_fraction), 64'd0);
      check("rst_out_exponent", 64'(e_obs),            64'd0);
      check("rst_flags",        64'({bus.out_zero, bus.out_denormal, bus.out_overflow}), 64'd0);
      check("rst_out_cycles",   64'(bus.out_cycles),   64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Already normalized
      run_op(49'h0_8000_0000_0000, 10'd100, 49'h0_8000_0000_0000, 10'd100, 0, 0, 0, 6'd1);
      // Overflow right shift
      run_op(49'h1_0000_0000_0001, 10'd100, OVF_FRAC, 10'd101, 0, 0, 0, 6'd1);
      // Overflow pushing exponent to EXP_MAX
      run_op(49'h1_0000_0000_0001, 10'd254, OVF_FRAC, 10'd255, 0, 0, 1, 6'd1);
      // Normalized just below and at EXP_MAX
      run_op(49'h0_8000_0000_0000, 10'd254, 49'h0_8000_0000_0000, 10'd254, 0, 0, 0, 6'd1);
      run_op(49'h0_8000_0000_0000, 10'd255, 49'h0_8000_0000_0000, 10'd255, 0, 0, 1, 6'd1);
      // Underflow: bit 43, one full step then done
      run_op(49'h0_0800_0000_0000, 10'd100, 49'h0_8000_0000_0000, 10'd96, 0, 0, 0, 6'd2);
      // Underflow: bit 40, shifts of 4 then 3
      run_op(49'h0_0100_0000_0000, 10'd100, 49'h0_8000_0000_0000, 10'd93, 0, 0, 0, 6'd3);
      // Denormal: shift capped by exponent floor
      run_op(49'h0_0000_0000_0001, 10'd3, 49'h0_0000_0000_0004, 10'd0, 0, 1, 0, 6'd2);
      run_op(49'h0_2000_0000_0000, 10'd2, 49'h0_4000_0000_0000, 10'd0, 0, 1, 0, 6'd2);
      // Zero fraction, including zero taking priority over the floor
      run_op(49'h0, 10'd77, 49'h0, 10'd0, 1, 0, 0, 6'd1);
      run_op(49'h0, 10'd1,  49'h0, 10'd0, 1, 0, 0, 6'd1);

      // Backpressure: hold DONE for 5 cycles with an in_valid pulse mid-way
      push_exp(49'h0_8000_0000_0000, 10'd50, 0, 0, 0, 6'd1);
      accept(49'h0_8000_0000_0000, 10'd50);
      wait_and_compare();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            bus.in_valid    = 1'b1;
            bus.in_fraction = 49'h1_0000_0000_0000;
            bus.in_exponent = 10'd7;
         end
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         e_obs = bus.out_exponent;
         check("bp_out_valid",    64'(bus.out_valid),    64'd1);
         check("bp_in_ready",     64'(bus.in_ready),     64'd0);
         check("bp_out_fraction", 64'(bus.out_fraction), 64'h0_8000_0000_0000);
         check("bp_out_exponent", 64'(e_obs),            64'd50);
      end
      release_result();
      stale = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stale = 1'b1;
      end
      check("bp_pulse_ignored", 64'(stale), 64'd0);

      // Reset while in NORM
      accept(49'h0_0800_0000_0000, 10'd100);
      @(posedge clk); #1;
      check("mid_norm_no_valid", 64'(bus.out_valid), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      e_obs = bus.out_exponent;
      check("midrst_in_ready",     64'(bus.in_ready),     64'd1);
      check("midrst_out_valid",    64'(bus.out_valid),    64'd0);
      check("midrst_out_fraction", 64'(bus.out_fraction), 64'd0);
      check("midrst_out_exponent", 64'(e_obs),            64'd0);
      check("midrst_flags",        64'({bus.out_zero, bus.out_denormal, bus.out_overflow}), 64'd0);
      check("midrst_out_cycles",   64'(bus.out_cycles),   64'd0);
      stale = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      check("midrst_no_stale", 64'(stale), 64'd0);

      // Operation after reset still works
      run_op(49'h0_0800_0000_0000, 10'd100, 49'h0_8000_0000_0000, 10'd96, 0, 0, 0, 6'd2);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
